shot_judge: RTL

//   Upstream stage of target_gen. Launches a shot from the player row on fire,

---
 rtl/game_pkg.sv | 15 +
 rtl/shot_stepper.sv | 42 ++++
 rtl/shot_judge.sv | 105 ++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the shot/target game blocks: grid width, FSM encoding
// and the row shots launch from.
package game_pkg;

    localparam int COORD_W    = 5;
    localparam int PLAYER_ROW = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_FLY      = 2'd1;
    localparam state_t ST_JUDGE    = 2'd2;
    localparam state_t ST_GAMEOVER = 2'd3;

endpackage

// File: rtl/shot_stepper.sv
// Advances a shot one row every STEP_DIV enabled cycles until it reaches the
// latched target row; done flags arrival.
module shot_stepper #(
    parameter int COORD_W  = game_pkg::COORD_W,
    parameter int STEP_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               enable,
    input  logic [COORD_W-1:0] ty,
    output logic [COORD_W-1:0] shot_y,
    output logic               done
);
    import game_pkg::*;

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] step_cnt;

    assign done = (shot_y == ty);

    // Movement stops once done, so shot_y never passes the target row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_cnt <= '0;
            shot_y   <= '0;
        end else if (load) begin
            step_cnt <= '0;
            shot_y   <= COORD_W'(PLAYER_ROW);
        end else if (enable && !done) begin
            if (step_cnt == CNT_MAX) begin
                step_cnt <= '0;
                shot_y   <= shot_y + COORD_W'(1);
            end else begin
                step_cnt <= step_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/shot_judge.sv
// Launches a shot on fire, flies it to the target row latched at launch, and
// judges hit/miss with a one-cycle result pulse; keeps score, misses, game over.
module shot_judge #(
    parameter int COORD_W    = game_pkg::COORD_W,
    parameter int STEP_DIV   = 4,
    parameter int SCORE_W    = 8,
    parameter int MAX_MISSES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fire,
    input  logic [COORD_W-1:0] aim_x,
    input  logic [COORD_W-1:0] target_x,
    input  logic [COORD_W-1:0] target_y,
    output logic               shot_active,
    output logic [COORD_W-1:0] shot_x,
    output logic [COORD_W-1:0] shot_y,
    output logic               result_valid,
    output logic               hit,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         misses,
    output logic               game_over
);
    import game_pkg::*;

    localparam logic [1:0]         MISS_LIMIT = 2'(MAX_MISSES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_t             state;
    state_t             state_next;
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
    logic               launch;
    logic               done;
    logic               last_miss;

    // GAMEOVER is its own state, so IDLE already implies game_over == 0.
    assign launch    = (state == ST_IDLE) && fire;
    assign last_miss = ((misses + 2'd1) == MISS_LIMIT);

    shot_stepper #(
        .COORD_W  (COORD_W),
        .STEP_DIV (STEP_DIV)
    ) u_stepper (
        .clk    (clk),
        .reset  (reset),
        .load   (launch),
        .enable (state == ST_FLY),
        .ty     (ty),
        .shot_y (shot_y),
        .done   (done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (fire) state_next = ST_FLY;
            ST_FLY:      if (done) state_next = ST_JUDGE;
            ST_JUDGE:    state_next = (!hit && last_miss) ? ST_GAMEOVER : ST_IDLE;
            ST_GAMEOVER: state_next = ST_GAMEOVER;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        shot_active  = (state == ST_FLY) || (state == ST_JUDGE);
        result_valid = (state == ST_JUDGE);
        game_over    = (state == ST_GAMEOVER);
    end

    // hit is only ever set on the FLY->JUDGE edge, so it reads 0 outside JUDGE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shot_x <= '0;
            tx     <= '0;
            ty     <= '0;
            hit    <= 1'b0;
            score  <= '0;
            misses <= '0;
        end else begin
            hit <= (state == ST_FLY) && done && (shot_x == tx);
            if (launch) begin
                shot_x <= aim_x;
                tx     <= target_x;
                ty     <= target_y;
            end
            if (state == ST_JUDGE) begin
                if (hit) begin
                    if (score != SCORE_MAX) score <= score + SCORE_W'(1);
                end else begin
                    misses <= misses + 2'd1;
                end
            end
        end
    end

endmodule
